// File: rtl/or1k_dbg_stall_unit.sv
// OR1K debug stall/reset responder in the CPU clock domain.
// Freezes and drains the pipeline on debug stops and drives the breakpoint handshake.
module or1k_dbg_stall_unit #(
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic       cpu_clk_i,
    input  logic       rst_i,
    input  logic       dbg_stall_i,
    input  logic       dbg_rst_i,
    input  logic       retire_i,
    input  logic       trap_i,
    input  logic       step_en_i,
    input  logic       bus_busy_i,
    output logic       bp_o,
    output logic       freeze_o,
    output logic       halted_o,
    output logic       core_rst_o,
    output logic [1:0] stop_reason_o,
    output logic       timeout_o
);

    localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_bp;
    logic            w_bp_nxt;
    logic [1:0]      r_reason;
    logic [1:0]      w_reason_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;
    logic            r_core_rst;

    always_ff @(posedge cpu_clk_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_bp       <= 1'b0;
            r_reason   <= 2'b00;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
            r_core_rst <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bp       <= w_bp_nxt;
            r_reason   <= w_reason_nxt;
            r_cnt      <= w_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
            r_core_rst <= dbg_rst_i;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bp_nxt      = r_bp;
        w_reason_nxt  = r_reason;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        if (dbg_rst_i) begin
            w_state_nxt  = RUN;
            w_bp_nxt     = 1'b0;
            w_reason_nxt = 2'b00;
            w_cnt_nxt    = '0;
        end else begin
            // Debug side acknowledges a breakpoint by holding stall high
            if (r_bp && dbg_stall_i)
                w_bp_nxt = 1'b0;
            case (r_state)
                RUN: begin
                    if (retire_i && (trap_i || step_en_i || dbg_stall_i) ||
                        dbg_stall_i) begin
                        w_state_nxt   = DRAIN;
                        w_cnt_nxt     = '0;
                        w_timeout_nxt = 1'b0;
                    end
                    if (retire_i && trap_i) begin
                        w_bp_nxt     = 1'b1;
                        w_reason_nxt = 2'b10;
                    end else if (retire_i && step_en_i) begin
                        w_bp_nxt     = 1'b1;
                        w_reason_nxt = 2'b11;
                    end else if (dbg_stall_i) begin
                        w_reason_nxt = 2'b01;
                    end
                end
                DRAIN: begin
                    if (r_cnt != {CW{1'b1}})
                        w_cnt_nxt = r_cnt + CW'(1);
                    if (!bus_busy_i) begin
                        w_state_nxt = HALTED;
                    end else if (r_cnt == LAST) begin
                        w_state_nxt   = HALTED;
                        w_timeout_nxt = 1'b1;
                    end
                end
                HALTED: begin
                    if (!dbg_stall_i && !r_bp)
                        w_state_nxt = RUN;
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    assign bp_o          = r_bp;
    assign freeze_o      = (r_state != RUN);
    assign halted_o      = (r_state == HALTED);
    assign core_rst_o    = r_core_rst;
    assign stop_reason_o = r_reason;
    assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_or1k_dbg_stall_unit.sv
// Scoreboard bench for or1k_dbg_stall_unit with directed vectors.
// Expected output vectors are queued by stimulus and checked by a monitor.
module tb_or1k_dbg_stall_unit;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       dbg_stall_i = 1'b0;
    logic       dbg_rst_i = 1'b0;
    logic       retire_i = 1'b0;
    logic       trap_i = 1'b0;
    logic       step_en_i = 1'b0;
    logic       bus_busy_i = 1'b0;
    logic       bp_o;
    logic       freeze_o;
    logic       halted_o;
    logic       core_rst_o;
    logic [1:0] stop_reason_o;
    logic       timeout_o;

    or1k_dbg_stall_unit #(.DRAIN_TIMEOUT(4)) dut (
        .cpu_clk_i     (clk),
        .rst_i         (rst_i),
        .dbg_stall_i   (dbg_stall_i),
        .dbg_rst_i     (dbg_rst_i),
        .retire_i      (retire_i),
        .trap_i        (trap_i),
        .step_en_i     (step_en_i),
        .bus_busy_i    (bus_busy_i),
        .bp_o          (bp_o),
        .freeze_o      (freeze_o),
        .halted_o      (halted_o),
        .core_rst_o    (core_rst_o),
        .stop_reason_o (stop_reason_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [6:0] exp;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    n_run = 0;
    int    n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // {freeze, halted, bp, reason[1:0], timeout, core_rst}
    function automatic logic [6:0] pk(bit f, bit h, bit b, bit [1:0] r,
                                      bit t, bit c);
        return {f, h, b, r, t, c};
    endfunction

    always @(negedge clk) begin
        logic [6:0] got;
        item_t      it;
        got = {freeze_o, halted_o, bp_o, stop_reason_o, timeout_o, core_rst_o};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            n_run++;
            if (it.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: sample missed (cycle %0d, now %0d)",
                         it.name, it.cyc, cyc);
            end else if (got !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got f/h/bp/rsn/to/cr=%b required %b",
                         it.name, got, it.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [6:0] e);
        item_t it;
        it.cyc  = cyc;
        it.name = name;
        it.exp  = e;
        sb.push_back(it);
    endtask

    initial begin
        tick();
        chk("reset", pk(0, 0, 0, 2'b00, 0, 0));
        rst_i = 1'b0;
        tick();
        chk("idle_run", pk(0, 0, 0, 2'b00, 0, 0));

        // host stall, idle bus
        dbg_stall_i = 1'b1;
        tick();
        chk("host_drain", pk(1, 0, 0, 2'b01, 0, 0));
        tick();
        chk("host_halted", pk(1, 1, 0, 2'b01, 0, 0));
        dbg_stall_i = 1'b0;
        tick();
        chk("host_resume", pk(0, 0, 0, 2'b01, 0, 0));

        // trap with busy bus
        retire_i = 1'b1; trap_i = 1'b1; bus_busy_i = 1'b1;
        tick();
        chk("trap_drain", pk(1, 0, 1, 2'b10, 0, 0));
        retire_i = 1'b0; trap_i = 1'b0;
        tick();
        tick();
        chk("trap_busy", pk(1, 0, 1, 2'b10, 0, 0));
        bus_busy_i = 1'b0;
        tick();
        chk("trap_halted", pk(1, 1, 1, 2'b10, 0, 0));
        retire_i = 1'b1; trap_i = 1'b1;
        dbg_stall_i = 1'b1;
        tick();
        chk("trap_ack", pk(1, 1, 0, 2'b10, 0, 0));
        retire_i = 1'b0; trap_i = 1'b0;
        dbg_stall_i = 1'b0;
        tick();
        chk("trap_resume", pk(0, 0, 0, 2'b10, 0, 0));

        // drain timeout with stuck bus
        dbg_stall_i = 1'b1; bus_busy_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("to_last_drain", pk(1, 0, 0, 2'b01, 0, 0));
        tick();
        chk("to_halted", pk(1, 1, 0, 2'b01, 1, 0));
        dbg_stall_i = 1'b0; bus_busy_i = 1'b0;
        tick();
        chk("to_sticky", pk(0, 0, 0, 2'b01, 1, 0));
        dbg_stall_i = 1'b1;
        tick();
        chk("to_cleared", pk(1, 0, 0, 2'b01, 0, 0));
        tick();
        chk("to_idle_halt", pk(1, 1, 0, 2'b01, 0, 0));
        dbg_stall_i = 1'b0;
        tick();

        // single step, three resumes
        step_en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            retire_i = 1'b1;
            tick();
            chk($sformatf("step%0d_stop", i), pk(1, 0, 1, 2'b11, 0, 0));
            retire_i = 1'b0;
            tick();
            chk($sformatf("step%0d_halt", i), pk(1, 1, 1, 2'b11, 0, 0));
            dbg_stall_i = 1'b1;
            tick();
            chk($sformatf("step%0d_ack", i), pk(1, 1, 0, 2'b11, 0, 0));
            dbg_stall_i = 1'b0;
            tick();
            chk($sformatf("step%0d_run", i), pk(0, 0, 0, 2'b11, 0, 0));
        end

        // trap, step and stall together
        retire_i = 1'b1; trap_i = 1'b1; dbg_stall_i = 1'b1;
        tick();
        chk("simul_stop", pk(1, 0, 1, 2'b10, 0, 0));
        retire_i = 1'b0; trap_i = 1'b0;
        tick();
        chk("simul_1cyc_bp", pk(1, 1, 0, 2'b10, 0, 0));
        step_en_i = 1'b0;

        // debug reset while halted and stalled
        dbg_rst_i = 1'b1;
        tick();
        chk("dbgrst_run", pk(0, 0, 0, 2'b00, 0, 1));
        dbg_rst_i = 1'b0;
        tick();
        chk("dbgrst_drain", pk(1, 0, 0, 2'b01, 0, 0));
        tick();
        chk("dbgrst_halt", pk(1, 1, 0, 2'b01, 0, 0));

        // rst_i mid-drain
        dbg_stall_i = 1'b0; bus_busy_i = 1'b1;
        tick();
        retire_i = 1'b1; trap_i = 1'b1;
        tick();
        chk("rst_pre", pk(1, 0, 1, 2'b10, 0, 0));
        retire_i = 1'b0; trap_i = 1'b0;
        rst_i = 1'b1;
        tick();
        chk("rst_abort", pk(0, 0, 0, 2'b00, 0, 0));
        rst_i = 1'b0; bus_busy_i = 1'b0;
        tick();
        chk("rst_after", pk(0, 0, 0, 2'b00, 0, 0));

        tick();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
